exec_mem_stage: RTL and testbench
=================================

EXEC_MEM_STAGE -- requirements
Module: exec_mem_stage

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits.
REQ-002 Parameter ADDR_W, default 4, memory address width.
REQ-003 Parameter TIMEOUT, default 15, maximum cycles MEM waits for mem_ack.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous reset, active-high.
REQ-006 in_valid  input  1  decoded op present.
REQ-007 in_ready  output  1  stage can accept an op.
REQ-008 alu_op  input  2  decoder ALU select: 00 ADD, 01 SUB, 10 AND, 11 OR.
REQ-009 mem_write  input  1  decoder store flag.
REQ-010 op_a, op_b  input  WIDTH  operands.
REQ-011 addr  input  ADDR_W  store address.
REQ-012 mem_req  output  1  write request to memory.
REQ-013 mem_addr  output  ADDR_W  write address.
REQ-014 mem_wdata  output  WIDTH  write data.
REQ-015 mem_ack  input  1  memory accepted write.
REQ-016 out_valid  output  1  result available.
REQ-017 out_ready  input  1  consumer takes result.
REQ-018 result  output  WIDTH  ALU result.
REQ-019 carry  output  1  ADD carry-out / SUB borrow; 0 for AND/OR.
REQ-020 err  output  1  store timed out.
REQ-021 op_count  output  16  completed output handshakes.

Function
REQ-022 FSM states IDLE, EXEC, MEM, DONE; in_ready SHALL be 1 only in IDLE.
REQ-023 IDLE: in_valid=1 SHALL capture alu_op, mem_write, op_a, op_b, addr and go to EXEC; otherwise stay in IDLE.
REQ-024 EXEC (exactly one cycle) SHALL register result and carry; next state MEM if captured mem_write=1, else DONE.
REQ-025 Arithmetic SHALL be modulo 2^WIDTH; SUB is op_a-op_b, with carry=1 when op_a<op_b.
REQ-026 MEM: mem_req=1, mem_addr=captured addr, mem_wdata=result, all held stable until exit.
REQ-027 MEM: mem_ack=1 SHALL go to DONE with err=0; mem_req SHALL drop the following cycle.
REQ-028 MEM: a wait counter SHALL clear on entry and increment each cycle without ack; on the cycle it reaches TIMEOUT without ack, SHALL go to DONE with err=1.
REQ-029 mem_ack outside MEM SHALL be ignored.
REQ-030 DONE: out_valid=1, with result, carry and err held stable until out_ready=1; then go to IDLE and increment op_count.
REQ-031 op_count SHALL wrap from 0xFFFF to 0x0000.
REQ-032 Latency: non-store accepted at cycle N SHALL give out_valid at N+2; store with ack at cycle M SHALL give out_valid at M+1.
REQ-033 No new op SHALL be accepted until the current op's output handshake completes; back-to-back throughput is one op per 3 cycles minimum.

Reset
REQ-034 rst=1 SHALL force IDLE, in_ready=1, and set mem_req, out_valid, result, carry, err, op_count and the wait counter to 0.
REQ-035 rst SHALL take priority over every handshake in the same cycle; an in-flight op, including one in MEM, SHALL be discarded with no output.
REQ-036 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-037 ADD 0xF0+0x20, mem_write=0 -> out_valid 2 cycles after accept, result=0x10, carry=1, err=0, op_count=1 after handshake.
REQ-038 SUB 0x05-0x07 -> result=0xFE, carry=1; AND 0xCC,0xAA -> 0x88; OR 0xCC,0xAA -> 0xEE; carry=0 for AND and OR.
REQ-039 Store ADD 0x03+0x04 at addr 0x9, ack after 3 cycles -> mem_req high 3 cycles with addr=0x9, wdata=0x07; out_valid the cycle after ack; err=0.
REQ-040 Store with mem_ack held 0 -> mem_req high TIMEOUT cycles, then out_valid=1 with err=1; a later ack is ignored.
REQ-041 out_ready held 0 for 5 cycles -> result stable, in_valid pulses not accepted, in_ready=0.
REQ-042 rst asserted mid-MEM -> next cycle mem_req=0, out_valid=0, op_count=0, in_ready=1; no output is produced for the aborted op.

Source files
------------

// File: rtl/exec_mem_stage.sv
// rtl/exec_mem_stage.sv - execute/memory stage: one ALU op, optional store with ack timeout, result handshake
module exec_mem_stage #(
    parameter int WIDTH   = 8,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        alu_op,
    input  logic              mem_write,
    input  logic [WIDTH-1:0]  op_a,
    input  logic [WIDTH-1:0]  op_b,
    input  logic [ADDR_W-1:0] addr,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WIDTH-1:0]  mem_wdata,
    input  logic              mem_ack,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              carry,
    output logic              err,
    output logic [15:0]       op_count
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, EXEC, MEM, DONE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic                store_q, store_d;
    logic [WIDTH-1:0]    a_q, a_d, b_q, b_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic                carry_q, carry_d;
    logic                err_q, err_d;
    logic [15:0]         count_q, count_d;
    logic [CW-1:0]       wait_q, wait_d;
    logic [WIDTH:0]      alu_full;
    logic [CW-1:0]       wait_inc;

    // Top bit of the widened subtraction is the borrow, i.e. op_a < op_b.
    always_comb begin
        alu_full = '0;
        case (op_q)
            2'b00:   alu_full = {1'b0, a_q} + {1'b0, b_q};
            2'b01:   alu_full = {1'b0, a_q} - {1'b0, b_q};
            2'b10:   alu_full = {1'b0, a_q & b_q};
            default: alu_full = {1'b0, a_q | b_q};
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        store_d  = store_q;
        a_d      = a_q;
        b_d      = b_q;
        addr_d   = addr_q;
        result_d = result_q;
        carry_d  = carry_q;
        err_d    = err_q;
        count_d  = count_q;
        wait_d   = wait_q;
        wait_inc = wait_q + 1'b1;
        case (state_q)
            IDLE: if (in_valid) begin
                op_d    = alu_op;
                store_d = mem_write;
                a_d     = op_a;
                b_d     = op_b;
                addr_d  = addr;
                state_d = EXEC;
            end
            EXEC: begin
                result_d = alu_full[WIDTH-1:0];
                carry_d  = alu_full[WIDTH];
                err_d    = 1'b0;
                wait_d   = '0;
                state_d  = store_q ? MEM : DONE;
            end
            MEM: if (mem_ack) begin
                err_d   = 1'b0;
                state_d = DONE;
            end else begin
                wait_d = wait_inc;
                if (wait_inc == CW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: if (out_ready) begin
                count_d = count_q + 16'd1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            store_q  <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            addr_q   <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
            count_q  <= '0;
            wait_q   <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            store_q  <= store_d;
            a_q      <= a_d;
            b_q      <= b_d;
            addr_q   <= addr_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            err_q    <= err_d;
            count_q  <= count_d;
            wait_q   <= wait_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign mem_req   = (state_q == MEM);
    assign mem_addr  = addr_q;
    assign mem_wdata = result_q;
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign carry     = carry_q;
    assign err       = err_q;
    assign op_count  = count_q;
endmodule

// File: tb/tb_exec_mem_stage.sv
// tb/tb_exec_mem_stage.sv - directed bench with a cycle-level transaction model for exec_mem_stage
module tb_exec_mem_stage;
    localparam int TO = 6;

    logic       clk = 1'b0, rst = 1'b1;
    logic       in_valid = 1'b0, mem_write = 1'b0, mem_ack = 1'b0, out_ready = 1'b0;
    logic [1:0] alu_op = 2'b00;
    logic [7:0] op_a = '0, op_b = '0;
    logic [3:0] addr = '0;
    logic       in_ready, mem_req, out_valid, carry, err;
    logic [3:0] mem_addr;
    logic [7:0] mem_wdata, result;
    logic [15:0] op_count;

    exec_mem_stage #(.WIDTH(8), .ADDR_W(4), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .mem_write(mem_write), .op_a(op_a), .op_b(op_b), .addr(addr),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .carry(carry),
        .err(err), .op_count(op_count)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model_alu(input logic [1:0] op, input int a, input int b,
                                      output logic [7:0] r, output logic c);
        int s;
        case (op)
            2'd0: begin s = a + b; c = (s > 255); end
            2'd1: begin s = (a - b + 256) % 256; c = (a < b); end
            2'd2: begin s = a & b; c = 1'b0; end
            default: begin s = a | b; c = 1'b0; end
        endcase
        r = s[7:0];
    endfunction

    // Transaction model: an accepted op spends one cycle computing, then
    // either reports directly or waits in a store window for ack/timeout.
    bit         m_busy, m_done, m_mem, m_store, chk_en;
    int         m_age, m_wait;
    logic [7:0] m_res, x_res;
    logic       m_car, x_car, m_err;
    logic [3:0] m_addr;
    logic [15:0] m_cnt;

    always @(posedge clk) begin
        if (rst) begin
            m_busy = 0; m_done = 0; m_mem = 0; m_res = 0; m_car = 0; m_err = 0; m_cnt = 0;
        end else if (!m_busy) begin
            if (in_valid) begin
                m_busy = 1; m_age = 1; m_store = mem_write; m_addr = addr;
                model_alu(alu_op, int'(op_a), int'(op_b), x_res, x_car);
            end
        end else if (m_done) begin
            if (out_ready) begin m_busy = 0; m_done = 0; m_cnt = m_cnt + 16'd1; end
        end else if (!m_mem && m_age == 1) begin
            m_age = 2; m_res = x_res; m_car = x_car; m_err = 0;
            if (m_store) begin m_mem = 1; m_wait = 0; end else m_done = 1;
        end else if (m_mem) begin
            if (mem_ack) begin m_mem = 0; m_done = 1; end
            else begin
                m_wait++;
                if (m_wait == TO) begin m_mem = 0; m_done = 1; m_err = 1; end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("in_ready", in_ready, m_busy ? 0 : 1);
            chk("out_valid", out_valid, m_done);
            chk("mem_req", mem_req, m_mem);
            chk("op_count", op_count, m_cnt);
            if (m_mem) begin
                chk("mem_addr", mem_addr, m_addr);
                chk("mem_wdata", mem_wdata, m_res);
            end
            if (m_done) begin
                chk("result", result, m_res);
                chk("carry", carry, m_car);
                chk("err", err, m_err);
            end
        end
    end

    task automatic run_op(input logic [1:0] op, input logic mw, input logic [7:0] a, input logic [7:0] b,
                          input logic [3:0] ad, input int ack_after, input int hold,
                          output int lat, output int mcyc, output int ack_cyc,
                          output logic [7:0] r, output logic c, output logic e);
        @(negedge clk);
        alu_op = op; mem_write = mw; op_a = a; op_b = b; addr = ad; in_valid = 1;
        @(negedge clk);
        in_valid = 0;
        lat = 1; mcyc = 0; ack_cyc = -1;
        while (!out_valid && lat < 100) begin
            if (mem_req) begin
                mcyc++;
                mem_ack = (mcyc == ack_after);
                if (mem_ack) ack_cyc = lat;
            end else mem_ack = 0;
            @(negedge clk);
            lat++;
        end
        mem_ack = 0;
        if (lat >= 100) chk("op_no_out_valid", out_valid, 1);
        r = result; c = carry; e = err;
        for (int i = 0; i < hold; i++) begin
            in_valid = i[0];
            alu_op = 2'(i);
            @(negedge clk);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_result", result, r);
        end
        in_valid = 0; out_ready = 1;
        @(negedge clk);
        out_ready = 0;
    endtask

    int lat, mcyc, ackc;
    logic [7:0] r;
    logic c, e;

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_result", result, 0);
        chk("rst_err", err, 0);
        chk("rst_op_count", op_count, 0);
        chk_en = 1;
        rst = 0;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);

        run_op(2'd0, 0, 8'hF0, 8'h20, 4'h0, 0, 0, lat, mcyc, ackc, r, c, e);
        chk("add_lat", lat, 2); chk("add_res", r, 8'h10); chk("add_carry", c, 1);
        chk("add_err", e, 0); chk("add_count", op_count, 1); chk("add_in_ready", in_ready, 1);

        run_op(2'd1, 0, 8'h05, 8'h07, 4'h0, 0, 0, lat, mcyc, ackc, r, c, e);
        chk("sub_res", r, 8'hFE); chk("sub_borrow", c, 1);
        run_op(2'd1, 0, 8'h10, 8'h03, 4'h0, 0, 0, lat, mcyc, ackc, r, c, e);
        chk("sub2_res", r, 8'h0D); chk("sub2_borrow", c, 0);
        run_op(2'd2, 0, 8'hCC, 8'hAA, 4'h0, 0, 0, lat, mcyc, ackc, r, c, e);
        chk("and_res", r, 8'h88); chk("and_carry", c, 0);
        run_op(2'd3, 0, 8'hCC, 8'hAA, 4'h0, 0, 0, lat, mcyc, ackc, r, c, e);
        chk("or_res", r, 8'hEE); chk("or_carry", c, 0);

        run_op(2'd0, 1, 8'h03, 8'h04, 4'h9, 3, 0, lat, mcyc, ackc, r, c, e);
        chk("st_req_cycles", mcyc, 3); chk("st_lat", lat, 5); chk("st_after_ack", lat, ackc + 1);
        chk("st_res", r, 8'h07); chk("st_err", e, 0);
        @(negedge clk);
        chk("st_req_dropped", mem_req, 0);

        run_op(2'd3, 1, 8'h50, 8'h0A, 4'h2, 1, 0, lat, mcyc, ackc, r, c, e);
        chk("st1_req_cycles", mcyc, 1); chk("st1_lat", lat, 3); chk("st1_res", r, 8'h5A);

        run_op(2'd0, 1, 8'h11, 8'h22, 4'h5, 0, 0, lat, mcyc, ackc, r, c, e);
        chk("to_req_cycles", mcyc, TO); chk("to_err", e, 1); chk("to_res", r, 8'h33);
        mem_ack = 1;
        repeat (3) begin
            @(negedge clk);
            chk("late_ack_out_valid", out_valid, 0);
            chk("late_ack_in_ready", in_ready, 1);
        end
        mem_ack = 0;

        run_op(2'd0, 0, 8'h7F, 8'h01, 4'h0, 0, 5, lat, mcyc, ackc, r, c, e);
        chk("hold_res", r, 8'h80); chk("hold_carry", c, 0); chk("hold_count", op_count, 9);

        @(negedge clk);
        alu_op = 2'd0; mem_write = 1; op_a = 8'h01; op_b = 8'h01; addr = 4'h3; in_valid = 1;
        @(negedge clk); in_valid = 0;
        repeat (2) @(negedge clk);
        chk("mid_mem_req", mem_req, 1);
        rst = 1;
        @(negedge clk);
        chk("abort_mem_req", mem_req, 0); chk("abort_out_valid", out_valid, 0);
        chk("abort_op_count", op_count, 0); chk("abort_in_ready", in_ready, 1);
        rst = 0;
        repeat (4) begin
            @(negedge clk);
            chk("abort_no_output", out_valid, 0);
        end

        run_op(2'd1, 0, 8'h00, 8'h01, 4'h0, 0, 0, lat, mcyc, ackc, r, c, e);
        chk("after_rst_res", r, 8'hFF); chk("after_rst_carry", c, 1); chk("after_rst_count", op_count, 1);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        errors++;
        $display("FAIL watchdog: simulation did not complete");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
